// File: rtl/icache.sv
// Direct-mapped instruction cache with one 32-bit word per line, between the fetch unit and memory.
// A hit returns in one cycle. A miss refills the line through one word request that the memory side finishes with a done pulse.
module icache #(
    parameter int INDEX_BITS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        flush,
    input  logic        req_from_if,
    input  logic [31:0] pc_from_if,
    output logic        busy_to_if,
    output logic        ins_valid_to_if,
    output logic [31:0] ins_to_if,
    output logic [31:0] pc_to_if,
    output logic        enable_to_mem,
    output logic [31:0] addr_to_mem,
    input  logic        enable_from_mem,
    input  logic [31:0] ins_from_mem
);
    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = 30 - INDEX_BITS;

    typedef enum logic {IDLE, REFILL} state_t;
    state_t state;

    logic [LINES-1:0]    valid;
    logic [TAG_BITS-1:0] tag_mem  [LINES];
    logic [31:0]         data_mem [LINES];

    logic [INDEX_BITS-1:0] req_idx, fill_idx;
    logic [TAG_BITS-1:0]   req_tag, fill_tag;
    logic                  hit, fill_done;
    logic                  unused_pc_bits;

    assign req_idx  = pc_from_if[INDEX_BITS+1:2];
    assign req_tag  = pc_from_if[31:INDEX_BITS+2];
    // addr_to_mem doubles as the latched miss PC for the whole refill.
    assign fill_idx = addr_to_mem[INDEX_BITS+1:2];
    assign fill_tag = addr_to_mem[31:INDEX_BITS+2];
    assign unused_pc_bits = ^pc_from_if[1:0];

    assign hit        = valid[req_idx] && (tag_mem[req_idx] == req_tag);
    // A refill writes the line even when a flush arrives on the same edge, because the word is correct for its address.
    assign fill_done  = rdy && (state == REFILL) && enable_from_mem;
    assign busy_to_if = (state == REFILL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            valid           <= '0;
            ins_valid_to_if <= 1'b0;
            ins_to_if       <= '0;
            pc_to_if        <= '0;
            enable_to_mem   <= 1'b0;
            addr_to_mem     <= '0;
        end else if (rdy) begin
            ins_valid_to_if <= 1'b0;
            if (fill_done) valid[fill_idx] <= 1'b1;
            if (flush) begin
                state         <= IDLE;
                enable_to_mem <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (req_from_if) begin
                            if (hit) begin
                                ins_valid_to_if <= 1'b1;
                                ins_to_if       <= data_mem[req_idx];
                                pc_to_if        <= {pc_from_if[31:2], 2'b00};
                            end else begin
                                state         <= REFILL;
                                enable_to_mem <= 1'b1;
                                addr_to_mem   <= {pc_from_if[31:2], 2'b00};
                            end
                        end
                    end
                    REFILL: begin
                        if (enable_from_mem) begin
                            state           <= IDLE;
                            enable_to_mem   <= 1'b0;
                            ins_valid_to_if <= 1'b1;
                            ins_to_if       <= ins_from_mem;
                            pc_to_if        <= addr_to_mem;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Tag and data arrays have no reset; the valid bits alone qualify them.
    always_ff @(posedge clk) begin
        if (fill_done) begin
            tag_mem[fill_idx]  <= fill_tag;
            data_mem[fill_idx] <= ins_from_mem;
        end
    end
endmodule
